// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - CPU/memory-side signal bundle for the LC-3 memory-access stage
interface mem_access_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 16
) ();
  logic              LD_MAR;
  logic              LD_MDR;
  logic              Mem_Start;
  logic              Mem_WE;
  logic [DATA_W-1:0] Bus_In;
  logic [DATA_W-1:0] Mem_Data_In;
  logic [ADDR_W-1:0] MAR_Out;
  logic [DATA_W-1:0] MDR_Out;
  logic [ADDR_W-1:0] Mem_Addr;
  logic [DATA_W-1:0] Mem_Data_Out;
  logic              Mem_CE_n;
  logic              Mem_OE_n;
  logic              Mem_WE_n;
  logic              Mem_Ready;
  logic              Busy;

  // Control FSM, CPU bus and SRAM model side
  modport master (
    output LD_MAR, LD_MDR, Mem_Start, Mem_WE, Bus_In, Mem_Data_In,
    input  MAR_Out, MDR_Out, Mem_Addr, Mem_Data_Out,
    input  Mem_CE_n, Mem_OE_n, Mem_WE_n, Mem_Ready, Busy
  );

  // Memory-access stage side
  modport slave (
    input  LD_MAR, LD_MDR, Mem_Start, Mem_WE, Bus_In, Mem_Data_In,
    output MAR_Out, MDR_Out, Mem_Addr, Mem_Data_Out,
    output Mem_CE_n, Mem_OE_n, Mem_WE_n, Mem_Ready, Busy
  );
endinterface

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MAR/MDR owner sequencing fixed-wait-state SRAM read/write cycles
module mem_access_ctrl #(
  parameter int WAIT_STATES = 2,
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 16
) (
  input logic              Clk,
  input logic              Reset_n,
  mem_access_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  localparam logic [3:0] LAST_CNT = 4'(WAIT_STATES - 1);

  state_t            state;
  state_t            state_next;
  logic [3:0]        cnt;
  logic              we_lat;
  logic [ADDR_W-1:0] mar;
  logic [DATA_W-1:0] mdr;
  logic              last_cycle;
  logic              ce_n;
  logic              oe_n;
  logic              we_n;
  logic              ready;
  logic              busy;

  assign last_cycle = (state == ACCESS) && (cnt == LAST_CNT);

  // State register; reset drops straight to IDLE so strobes release at once
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: start from IDLE, hold ACCESS for WAIT_STATES cycles, one DONE cycle
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.Mem_Start) state_next = ACCESS;
      ACCESS:  if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Strobe/status decode purely from registered state and latched access type
  always_comb begin
    ce_n  = 1'b1;
    oe_n  = 1'b1;
    we_n  = 1'b1;
    ready = 1'b0;
    busy  = 1'b0;
    case (state)
      ACCESS: begin
        ce_n = 1'b0;
        oe_n = we_lat;
        we_n = ~we_lat;
        busy = 1'b1;
      end
      DONE: begin
        ready = 1'b1;
        busy  = 1'b1;
      end
      default: ;
    endcase
  end

  // MAR/MDR loads in IDLE (before a same-cycle start), wait counter, read capture
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      mar    <= '0;
      mdr    <= '0;
      cnt    <= '0;
      we_lat <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= '0;
          if (bus.LD_MAR)    mar    <= ADDR_W'(bus.Bus_In);
          if (bus.LD_MDR)    mdr    <= bus.Bus_In;
          if (bus.Mem_Start) we_lat <= bus.Mem_WE;
        end
        ACCESS: begin
          cnt <= cnt + 4'd1;
          if (last_cycle && !we_lat) mdr <= bus.Mem_Data_In;
        end
        default: cnt <= '0;
      endcase
    end
  end

  assign bus.MAR_Out      = mar;
  assign bus.MDR_Out      = mdr;
  assign bus.Mem_Addr     = mar;
  assign bus.Mem_Data_Out = mdr;
  assign bus.Mem_CE_n     = ce_n;
  assign bus.Mem_OE_n     = oe_n;
  assign bus.Mem_WE_n     = we_n;
  assign bus.Mem_Ready    = ready;
  assign bus.Busy         = busy;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl with a cycle-timeline reference model
module tb_mem_access_ctrl;

  localparam int WS = 2;

  logic Clk = 1'b0;
  logic Reset_n;
  int   checks   = 0;
  int   failures = 0;

  // Reference model: architectural MAR/MDR contents
  logic [15:0] mar_m;
  logic [15:0] mdr_m;

  mem_access_ctrl_if #(.DATA_W(16), .ADDR_W(16)) bus ();

  mem_access_ctrl #(.WAIT_STATES(WS), .DATA_W(16), .ADDR_W(16)) dut (
    .Clk     (Clk),
    .Reset_n (Reset_n),
    .bus     (bus)
  );

  always #5 Clk = ~Clk;

  // {CE_n, OE_n, WE_n, Ready, Busy}
  function automatic logic [4:0] ctl_obs();
    return {bus.Mem_CE_n, bus.Mem_OE_n, bus.Mem_WE_n, bus.Mem_Ready, bus.Busy};
  endfunction

  task automatic clear_inputs();
    bus.LD_MAR      = 1'b0;
    bus.LD_MDR      = 1'b0;
    bus.Mem_Start   = 1'b0;
    bus.Mem_WE      = 1'($urandom);
    bus.Bus_In      = 16'($urandom);
    bus.Mem_Data_In = 16'($urandom);
  endtask

  // One IDLE cycle of loads; entered and left at a falling edge
  task automatic idle_load(input bit ld_mar, input bit ld_mdr, input logic [15:0] val);
    bus.LD_MAR    = ld_mar;
    bus.LD_MDR    = ld_mdr;
    bus.Bus_In    = val;
    bus.Mem_Start = 1'b0;
    if (ld_mar) mar_m = val;
    if (ld_mdr) mdr_m = val;
    @(negedge Clk);
    checks++;
    if ({bus.MAR_Out, bus.MDR_Out, bus.Busy} !== {mar_m, mdr_m, 1'b0}) begin
      failures++;
      $display("FAIL idle_load mar/mdr/busy got=%h/%h/%b exp=%h/%h/0",
               bus.MAR_Out, bus.MDR_Out, bus.Busy, mar_m, mdr_m);
    end
    clear_inputs();
  endtask

  // Caller has driven Mem_Start for the current IDLE cycle (cycle N). Walks
  // cycles N+1 .. N+WS+2 checking the access timeline, returns at the falling
  // edge of the IDLE cycle that follows DONE.
  task automatic do_access(input bit we, input logic [15:0] rdata, input bit noise,
                           input bit keep_start, input string tag);
    logic [4:0] exp_ctl;
    for (int k = 1; k <= WS + 2; k++) begin
      @(negedge Clk);
      if (k <= WS)          exp_ctl = {1'b0, we, ~we, 1'b0, 1'b1};
      else if (k == WS + 1) exp_ctl = 5'b11111;
      else                  exp_ctl = 5'b11100;
      if (k == WS + 1 && !we) mdr_m = rdata;
      checks++;
      if (ctl_obs() !== exp_ctl) begin
        failures++;
        $display("FAIL %s ctl cyc=%0d ce_oe_we_rdy_busy got=%b exp=%b", tag, k, ctl_obs(), exp_ctl);
      end
      checks++;
      if ({bus.MAR_Out, bus.Mem_Addr} !== {mar_m, mar_m}) begin
        failures++;
        $display("FAIL %s mar cyc=%0d got=%h/%h exp=%h", tag, k, bus.MAR_Out, bus.Mem_Addr, mar_m);
      end
      checks++;
      if ({bus.MDR_Out, bus.Mem_Data_Out} !== {mdr_m, mdr_m}) begin
        failures++;
        $display("FAIL %s mdr cyc=%0d got=%h/%h exp=%h", tag, k, bus.MDR_Out, bus.Mem_Data_Out, mdr_m);
      end
      bus.Mem_Data_In = (k == WS) ? rdata : 16'($urandom);
      if (noise && k <= WS + 1) begin
        bus.LD_MAR    = 1'b1;
        bus.LD_MDR    = 1'b1;
        bus.Bus_In    = 16'($urandom);
        bus.Mem_Start = 1'b1;
        bus.Mem_WE    = ~we;
      end else begin
        bus.LD_MAR = 1'b0;
        bus.LD_MDR = 1'b0;
        bus.Bus_In = 16'($urandom);
        if (!keep_start) begin
          bus.Mem_Start = 1'b0;
          bus.Mem_WE    = 1'($urandom);
        end
      end
    end
  endtask

  task automatic test_reset();
    Reset_n = 1'b0;
    clear_inputs();
    mar_m = 16'h0000;
    mdr_m = 16'h0000;
    repeat (2) @(negedge Clk);
    checks++;
    if (ctl_obs() !== 5'b11100) begin
      failures++;
      $display("FAIL reset ctl got=%b exp=11100", ctl_obs());
    end
    checks++;
    if ({bus.MAR_Out, bus.MDR_Out} !== 32'h0) begin
      failures++;
      $display("FAIL reset mar_mdr got=%h/%h exp=0000/0000", bus.MAR_Out, bus.MDR_Out);
    end
    Reset_n = 1'b1;
    @(negedge Clk);
    checks++;
    if ({ctl_obs(), bus.MAR_Out, bus.MDR_Out} !== {5'b11100, 32'h0}) begin
      failures++;
      $display("FAIL reset_release got=%b/%h/%h exp=11100/0000/0000", ctl_obs(), bus.MAR_Out, bus.MDR_Out);
    end
  endtask

  task automatic test_read();
    idle_load(1'b1, 1'b0, 16'h3000);
    bus.Mem_Start = 1'b1;
    bus.Mem_WE    = 1'b0;
    do_access(1'b0, 16'hBEEF, 1'b0, 1'b0, "read");
  endtask

  task automatic test_write();
    idle_load(1'b1, 1'b0, 16'h4002);
    idle_load(1'b0, 1'b1, 16'h1234);
    bus.Mem_Start = 1'b1;
    bus.Mem_WE    = 1'b1;
    do_access(1'b1, 16'h0000, 1'b0, 1'b0, "write");
  endtask

  task automatic test_ignored_while_busy();
    idle_load(1'b1, 1'b0, 16'h3000);
    bus.Mem_Start = 1'b1;
    bus.Mem_WE    = 1'b0;
    do_access(1'b0, 16'h5A5A, 1'b1, 1'b0, "ignored");
  endtask

  task automatic test_reset_mid_access();
    idle_load(1'b1, 1'b0, 16'h2222);
    bus.Mem_Start = 1'b1;
    bus.Mem_WE    = 1'b0;
    @(negedge Clk);
    checks++;
    if (ctl_obs() !== 5'b00101) begin
      failures++;
      $display("FAIL rst_mid first_access got=%b exp=00101", ctl_obs());
    end
    #2 Reset_n = 1'b0;
    mar_m = 16'h0000;
    mdr_m = 16'h0000;
    #1;
    checks++;
    if ({ctl_obs(), bus.MAR_Out, bus.MDR_Out} !== {5'b11100, 32'h0}) begin
      failures++;
      $display("FAIL rst_mid async got=%b/%h/%h exp=11100/0000/0000", ctl_obs(), bus.MAR_Out, bus.MDR_Out);
    end
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      checks++;
      if (ctl_obs() !== 5'b11100) begin
        failures++;
        $display("FAIL rst_mid held cyc=%0d got=%b exp=11100", i, ctl_obs());
      end
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge Clk);
      checks++;
      if ({ctl_obs(), bus.MDR_Out} !== {5'b11100, 16'h0000}) begin
        failures++;
        $display("FAIL rst_mid after cyc=%0d got=%b/%h exp=11100/0000", i, ctl_obs(), bus.MDR_Out);
      end
    end
  endtask

  task automatic test_simultaneous_load_start();
    bus.LD_MAR    = 1'b1;
    bus.Bus_In    = 16'h0055;
    bus.Mem_Start = 1'b1;
    bus.Mem_WE    = 1'b0;
    mar_m = 16'h0055;
    do_access(1'b0, 16'hC0DE, 1'b0, 1'b0, "simul_read");
    bus.LD_MAR    = 1'b1;
    bus.LD_MDR    = 1'b1;
    bus.Bus_In    = 16'h7E57;
    bus.Mem_Start = 1'b1;
    bus.Mem_WE    = 1'b1;
    mar_m = 16'h7E57;
    mdr_m = 16'h7E57;
    do_access(1'b1, 16'h0000, 1'b0, 1'b0, "simul_write");
  endtask

  task automatic test_back_to_back();
    idle_load(1'b1, 1'b0, 16'h0100);
    bus.Mem_Start = 1'b1;
    bus.Mem_WE    = 1'b0;
    do_access(1'b0, 16'h1111, 1'b0, 1'b1, "b2b_0");
    bus.Mem_WE = 1'b1;
    do_access(1'b1, 16'h0000, 1'b0, 1'b1, "b2b_1");
    bus.Mem_WE = 1'b0;
    do_access(1'b0, 16'h2222, 1'b0, 1'b0, "b2b_2");
  endtask

  task automatic test_random();
    for (int i = 0; i < 24; i++) begin
      bit          we;
      int          mode;
      logic [15:0] addr;
      logic [15:0] data;
      we   = 1'($urandom);
      mode = int'($urandom_range(0, 2));
      addr = 16'($urandom);
      data = 16'($urandom);
      if (mode == 1) begin
        bus.LD_MAR = 1'b1;
        bus.LD_MDR = we;
        bus.Bus_In = addr;
        mar_m = addr;
        if (we) mdr_m = addr;
      end else begin
        idle_load(1'b1, 1'b0, addr);
        if (we) idle_load(1'b0, 1'b1, data);
      end
      bus.Mem_Start = 1'b1;
      bus.Mem_WE    = we;
      do_access(we, data, mode == 2, 1'b0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_read();
    test_write();
    test_ignored_while_busy();
    test_reset_mid_access();
    test_simultaneous_load_start();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
